// File: rtl/nrst_seq_pkg.sv
// Shared types and width helpers for the multi-domain reset sequencer.
package nrst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough to hold the larger of the two terminal counts.
    function automatic int cnt_width(input int min_assert, input int release_gap);
        return $clog2(max_int(min_assert, release_gap) + 1);
    endfunction

endpackage

// File: rtl/nrst_sequencer_timer.sv
// Up-counter with clear and a terminal-count compare against a runtime limit.
// Shared by the minimum-assert hold and the inter-channel release gap.
module rst_release_timer #(
    parameter int W = 4
) (
    input  logic         CLK_I,
    input  logic         NRST_I,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt;
    logic [W:0]   cnt_inc;

    // Terminal count fires on the edge where the count would reach the limit.
    assign cnt_inc = {1'b0, cnt} + (W + 1)'(1);
    assign tc      = en && (cnt_inc == {1'b0, limit});

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_inc[W-1:0];
        end
    end

endmodule

// File: rtl/nrst_sequencer.sv
// Reset sequencer: async assert, synchronised release, minimum hold, then
// per-channel release in index order with a fixed gap. SRST_I re-runs it.
module nrst_sequencer
    import nrst_seq_pkg::*;
#(
    parameter int STAGES      = 2,
    parameter int CHANNELS    = 4,
    parameter int MIN_ASSERT  = 8,
    parameter int RELEASE_GAP = 16
) (
    input  logic                CLK_I,
    input  logic                NRST_I,
    input  logic                SRST_I,
    output logic [CHANNELS-1:0] NRST_O,
    output logic                DONE_O
);

    localparam int CNT_W = cnt_width(MIN_ASSERT, RELEASE_GAP);
    localparam int IDX_W = $clog2(CHANNELS + 1);

    if (STAGES < 2) begin : g_bad_stages
        $error("nrst_sequencer: STAGES must be >= 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("nrst_sequencer: CHANNELS must be >= 1");
    end
    if (MIN_ASSERT < 1) begin : g_bad_min_assert
        $error("nrst_sequencer: MIN_ASSERT must be >= 1");
    end
    if (RELEASE_GAP < 1) begin : g_bad_release_gap
        $error("nrst_sequencer: RELEASE_GAP must be >= 1");
    end

    logic [STAGES-1:0]   sync_q;
    logic                rst_ok;
    seq_state_t          state_q, state_n;
    logic [CHANNELS-1:0] nrst_q, nrst_n;
    logic                done_q, done_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic                timer_clr, timer_en, timer_tc;
    logic [CNT_W-1:0]    timer_limit;

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_ok = sync_q[STAGES-1];

    // Timer controls depend only on registered state, keeping tc loop-free.
    assign timer_clr   = SRST_I;
    assign timer_en    = rst_ok && !SRST_I && (state_q != ST_RUN);
    assign timer_limit = (state_q == ST_RELEASE) ? CNT_W'(RELEASE_GAP) : CNT_W'(MIN_ASSERT);

    rst_release_timer #(
        .W (CNT_W)
    ) u_timer (
        .CLK_I  (CLK_I),
        .NRST_I (NRST_I),
        .clr    (timer_clr),
        .en     (timer_en),
        .limit  (timer_limit),
        .tc     (timer_tc)
    );

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            state_q <= ST_HOLD;
            nrst_q  <= '0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            nrst_q  <= nrst_n;
            done_q  <= done_n;
            idx_q   <= idx_n;
        end
    end

    always_comb begin
        state_n = state_q;
        nrst_n  = nrst_q;
        done_n  = done_q;
        idx_n   = idx_q;
        if (SRST_I) begin
            state_n = ST_HOLD;
            nrst_n  = '0;
            done_n  = 1'b0;
            idx_n   = '0;
        end else if (rst_ok) begin
            case (state_q)
                ST_HOLD: begin
                    if (timer_tc) begin
                        nrst_n[0] = 1'b1;
                        idx_n     = IDX_W'(1);
                        if (CHANNELS == 1) begin
                            done_n  = 1'b1;
                            state_n = ST_RUN;
                        end else begin
                            state_n = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (timer_tc) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                nrst_n[i] = 1'b1;
                            end
                        end
                        idx_n = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(CHANNELS - 1)) begin
                            done_n  = 1'b1;
                            state_n = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_n = ST_HOLD;
                end
            endcase
        end
    end

    assign NRST_O = nrst_q;
    assign DONE_O = done_q;

endmodule

// File: tb/tb_nrst_sequencer.sv
// Directed bench for nrst_sequencer: default build plus a CHANNELS=1 build.
module tb_nrst_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       srst;
    logic       srst1;
    logic [3:0] nrst_o;
    logic       done;
    logic [0:0] nrst1_o;
    logic       done1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_on = 1'b0;
    int k;
    int m;
    int n;

    typedef struct {
        int         off;
        logic [3:0] exp_o;
        logic       exp_done;
        logic       exp1;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    nrst_sequencer dut (
        .CLK_I  (clk),
        .NRST_I (nrst),
        .SRST_I (srst),
        .NRST_O (nrst_o),
        .DONE_O (done)
    );

    nrst_sequencer #(
        .STAGES      (3),
        .CHANNELS    (1),
        .MIN_ASSERT  (1),
        .RELEASE_GAP (1)
    ) dut1 (
        .CLK_I  (clk),
        .NRST_I (nrst),
        .SRST_I (srst1),
        .NRST_O (nrst1_o),
        .DONE_O (done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_edge(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vecs(input int base, input string tag);
        foreach (vecs[i]) begin
            wait_edge(base + vecs[i].off);
            chk($sformatf("%s_nrst_o@+%0d", tag, vecs[i].off), 32'(nrst_o), 32'(vecs[i].exp_o));
            chk($sformatf("%s_done@+%0d", tag, vecs[i].off), 32'(done), 32'(vecs[i].exp_done));
            chk($sformatf("%s_ch1@+%0d", tag, vecs[i].off), 32'(nrst1_o), 32'(vecs[i].exp1));
            chk($sformatf("%s_done1@+%0d", tag, vecs[i].off), 32'(done1), 32'(vecs[i].exp1));
        end
    endtask

    // Timeline after NRST_I release at edge k.
    task automatic load_release_vecs();
        vecs.delete();
        vecs.push_back('{0,  4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1,  4'b0000, 1'b0, 1'b0});
        vecs.push_back('{2,  4'b0000, 1'b0, 1'b0});
        vecs.push_back('{3,  4'b0000, 1'b0, 1'b1});
        vecs.push_back('{8,  4'b0000, 1'b0, 1'b1});
        vecs.push_back('{9,  4'b0001, 1'b0, 1'b1});
        vecs.push_back('{24, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{25, 4'b0011, 1'b0, 1'b1});
        vecs.push_back('{40, 4'b0011, 1'b0, 1'b1});
        vecs.push_back('{41, 4'b0111, 1'b0, 1'b1});
        vecs.push_back('{56, 4'b0111, 1'b0, 1'b1});
        vecs.push_back('{57, 4'b1111, 1'b1, 1'b1});
        vecs.push_back('{70, 4'b1111, 1'b1, 1'b1});
    endtask

    // Timeline after SRST_I first sampled low at edge n.
    task automatic load_srst_vecs();
        vecs.delete();
        vecs.push_back('{0,  4'b0000, 1'b0, 1'b1});
        vecs.push_back('{6,  4'b0000, 1'b0, 1'b1});
        vecs.push_back('{7,  4'b0001, 1'b0, 1'b1});
        vecs.push_back('{22, 4'b0001, 1'b0, 1'b1});
        vecs.push_back('{23, 4'b0011, 1'b0, 1'b1});
        vecs.push_back('{38, 4'b0011, 1'b0, 1'b1});
        vecs.push_back('{39, 4'b0111, 1'b0, 1'b1});
        vecs.push_back('{54, 4'b0111, 1'b0, 1'b1});
        vecs.push_back('{55, 4'b1111, 1'b1, 1'b1});
        vecs.push_back('{60, 4'b1111, 1'b1, 1'b1});
    endtask

    // Every cycle: thermometer code and DONE_O tracks the AND of the outputs.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("thermo", 32'((nrst_o & (nrst_o + 4'd1)) == 4'd0), 32'(1));
            chk("done_and", 32'(done), 32'(&nrst_o));
            chk("done1_and", 32'(done1), 32'(nrst1_o[0]));
        end
    end

    initial begin
        nrst  = 1'b0;
        srst  = 1'b0;
        srst1 = 1'b0;
        wait_edge(3);
        chk("reset_nrst_o", 32'(nrst_o), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_ch1", 32'(nrst1_o), 32'(0));
        chk("reset_done1", 32'(done1), 32'(0));
        mon_on = 1'b1;

        // Power-on release timeline
        k = cyc + 1;
        nrst = 1'b1;
        load_release_vecs();
        run_vecs(k, "rel");

        // Software reset from RUN, held for three edges
        srst = 1'b1;
        #1;
        chk("srst_no_comb", 32'(nrst_o), 32'hf);
        m = cyc + 1;
        wait_edge(m);
        chk("srst_m_nrst_o", 32'(nrst_o), 32'(0));
        chk("srst_m_done", 32'(done), 32'(0));
        wait_edge(m + 2);
        chk("srst_m2_nrst_o", 32'(nrst_o), 32'(0));
        srst = 1'b0;
        n = m + 3;
        load_srst_vecs();
        run_vecs(n, "srst");

        // NRST_I pulse mid-release drops every output without a clock edge
        nrst = 1'b0;
        #2;
        chk("async_run_nrst_o", 32'(nrst_o), 32'(0));
        wait_edge(cyc + 2);
        k = cyc + 1;
        nrst = 1'b1;
        wait_edge(k + 30);
        chk("mid_rel_nrst_o", 32'(nrst_o), 32'h3);
        #3;
        nrst = 1'b0;
        #1;
        chk("async_mid_nrst_o", 32'(nrst_o), 32'(0));
        chk("async_mid_done", 32'(done), 32'(0));
        chk("async_mid_ch1", 32'(nrst1_o), 32'(0));
        chk("async_mid_done1", 32'(done1), 32'(0));
        wait_edge(cyc + 3);
        k = cyc + 1;
        nrst = 1'b1;
        load_release_vecs();
        run_vecs(k, "rerel");

        // SRST_I held high across NRST_I release: release counts from SRST_I falling
        nrst = 1'b0;
        srst = 1'b1;
        wait_edge(cyc + 2);
        k = cyc + 1;
        nrst = 1'b1;
        wait_edge(k + 20);
        chk("both_hold_nrst_o", 32'(nrst_o), 32'(0));
        chk("both_hold_done", 32'(done), 32'(0));
        chk("both_hold_ch1", 32'(nrst1_o), 32'(1));
        srst = 1'b0;
        n = cyc + 1;
        load_srst_vecs();
        run_vecs(n, "both");

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
